// File: rtl/comparator_arbiter_pkg.sv
// Shared definitions for the comparator arbiter: FSM state encoding and
// the pointer-width helper used to size requester indices.
package comparator_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMP  = 2'd1,
      S_RESP = 2'd2,
      S_RSVD = 2'd3
   } state_e;

   // A single requester still needs a 1-bit index.
   function automatic int ptr_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/comparator.sv
// Unsigned magnitude comparator shared by all requesters of the arbiter.
// Purely combinational; the arbiter registers its outputs.
module Comparator #(
   parameter int DATAWIDTH = 32
) (
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   output logic                 gt,
   output logic                 lt,
   output logic                 eq
);

   assign gt = (a > b);
   assign lt = (a < b);
   assign eq = (a == b);

endmodule

// File: rtl/comparator_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit scanning from ptr
// upward with wrap-around.
module rr_picker #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic            found,
   output logic [PW-1:0]   winner
);

   logic [PW-1:0] cand [NREQ];

   // cand[k] is the requester index examined k places after ptr.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi] = PW'((int'(ptr) + gi) % NREQ);
   end

   always_comb begin
      found  = |req;
      winner = '0;
      // Scan from farthest to nearest so the closest set bit wins last.
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[cand[k]]) begin
            winner = cand[k];
         end
      end
   end

endmodule

// File: rtl/comparator_arbiter.sv
// Round-robin arbiter sharing one unsigned Comparator among NREQ requesters:
// IDLE latches the winner's operands, CMP registers the result, RESP pulses Done.
module comparator_arbiter
   import comparator_arbiter_pkg::*;
#(
   parameter int DATAWIDTH = 32,
   parameter int NREQ      = 4
) (
   input  logic                      Clk,
   input  logic                      Rst_n,
   input  logic [NREQ-1:0]           Req,
   input  logic [NREQ*DATAWIDTH-1:0] A_in,
   input  logic [NREQ*DATAWIDTH-1:0] B_in,
   output logic [NREQ-1:0]           Gnt,
   output logic [NREQ-1:0]           Done,
   output logic                      Gt,
   output logic                      Lt,
   output logic                      Eq,
   output logic                      Busy
);

   localparam int PW = ptr_width(NREQ);

   state_e                 state_q, state_d;
   logic [PW-1:0]          ptr_q, ptr_d;
   logic [PW-1:0]          grant_id_q, grant_id_d;
   logic [DATAWIDTH-1:0]   opa_q, opa_d;
   logic [DATAWIDTH-1:0]   opb_q, opb_d;
   logic [NREQ-1:0]        gnt_q, gnt_d;
   logic [NREQ-1:0]        done_q, done_d;
   logic                   gt_q, gt_d;
   logic                   lt_q, lt_d;
   logic                   eq_q, eq_d;

   logic                   found;
   logic [PW-1:0]          winner;
   logic                   cmp_gt, cmp_lt, cmp_eq;

   rr_picker #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_picker (
      .req    (Req),
      .ptr    (ptr_q),
      .found  (found),
      .winner (winner)
   );

   Comparator #(
      .DATAWIDTH (DATAWIDTH)
   ) u_cmp (
      .a  (opa_q),
      .b  (opb_q),
      .gt (cmp_gt),
      .lt (cmp_lt),
      .eq (cmp_eq)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_id_d = grant_id_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      gnt_d      = gnt_q;
      done_d     = '0;
      gt_d       = gt_q;
      lt_d       = lt_q;
      eq_d       = eq_q;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               opa_d      = A_in[int'(winner)*DATAWIDTH +: DATAWIDTH];
               opb_d      = B_in[int'(winner)*DATAWIDTH +: DATAWIDTH];
               grant_id_d = winner;
               gnt_d      = NREQ'(1) << winner;
               state_d    = S_CMP;
            end
         end
         S_CMP: begin
            gt_d    = cmp_gt;
            lt_d    = cmp_lt;
            eq_d    = cmp_eq;
            done_d  = gnt_q;
            state_d = S_RESP;
         end
         S_RESP: begin
            // The served requester moves to the back of the rotation.
            if (int'(grant_id_q) == NREQ - 1) begin
               ptr_d = '0;
            end else begin
               ptr_d = grant_id_q + PW'(1);
            end
            gnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         grant_id_q <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         gt_q       <= 1'b0;
         lt_q       <= 1'b0;
         eq_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_id_q <= grant_id_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         gt_q       <= gt_d;
         lt_q       <= lt_d;
         eq_q       <= eq_d;
      end
   end

   assign Gnt  = gnt_q;
   assign Done = done_q;
   assign Gt   = gt_q;
   assign Lt   = lt_q;
   assign Eq   = eq_q;
   assign Busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed bench for comparator_arbiter (NREQ=4, DATAWIDTH=32): reset, round-robin
// order, unsigned results, operand latching and reset during a compare.
module tb_comparator_arbiter;

   localparam int W = 32;
   localparam int N = 4;

   logic             Clk;
   logic             Rst_n;
   logic [N-1:0]     Req;
   logic [N*W-1:0]   A_in;
   logic [N*W-1:0]   B_in;
   logic [N-1:0]     Gnt;
   logic [N-1:0]     Done;
   logic             Gt, Lt, Eq, Busy;

   int n_cmp = 0;
   int n_err = 0;

   comparator_arbiter #(
      .DATAWIDTH (W),
      .NREQ      (N)
   ) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .Req   (Req),
      .A_in  (A_in),
      .B_in  (B_in),
      .Gnt   (Gnt),
      .Done  (Done),
      .Gt    (Gt),
      .Lt    (Lt),
      .Eq    (Eq),
      .Busy  (Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      Req   = 4'b1111;
      A_in  = '0;
      B_in  = '0;
      for (int c = 0; c < 4; c++) begin
         step();
         n_cmp++;
         if ({Busy, Gnt, Done, Gt, Lt, Eq} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_state cyc%0d: got busy=%b gnt=%b done=%b gle=%b%b%b required all 0",
                     c, Busy, Gnt, Done, Gt, Lt, Eq);
         end
      end
      $display("reset: held 4 cycles with Req=1111");
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_gnt;
      logic [N-1:0] exp_done;
      Rst_n = 1'b1;
      for (int c = 1; c <= 18; c++) begin
         step();
         exp_gnt  = (c % 3 == 0) ? 4'b0000 : (4'b0001 << (((c - 1) / 3) % 4));
         exp_done = (c % 3 == 2) ? (4'b0001 << (((c - 2) / 3) % 4)) : 4'b0000;
         n_cmp++;
         if (Gnt !== exp_gnt) begin
            n_err++;
            $display("FAIL rr_gnt cyc%0d: got %b required %b", c, Gnt, exp_gnt);
         end
         n_cmp++;
         if (Done !== exp_done) begin
            n_err++;
            $display("FAIL rr_done cyc%0d: got %b required %b", c, Done, exp_done);
         end
         if (exp_done != 0) $display("round_robin: cyc%0d done=%b", c, Done);
      end
      Req = '0;
      step();
   endtask

   // Serve one requester alone and check grant, done and the result flags.
   task automatic serve_one(input string name, input int id, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [2:0] exp_gle);
      logic [N-1:0] oh;
      oh = 4'b0001 << id;
      A_in[id*W +: W] = a;
      B_in[id*W +: W] = b;
      Req = oh;
      step();
      n_cmp++;
      if ({Gnt, Done, Busy} !== {oh, 4'b0000, 1'b1}) begin
         n_err++;
         $display("FAIL %s_cmp: got gnt=%b done=%b busy=%b required gnt=%b done=0000 busy=1",
                  name, Gnt, Done, Busy, oh);
      end
      step();
      Req = '0;
      n_cmp++;
      if ({Gnt, Done} !== {oh, oh}) begin
         n_err++;
         $display("FAIL %s_done: got gnt=%b done=%b required %b/%b", name, Gnt, Done, oh, oh);
      end
      n_cmp++;
      if ({Gt, Lt, Eq} !== exp_gle) begin
         n_err++;
         $display("FAIL %s_result: got gt/lt/eq=%b required %b", name, {Gt, Lt, Eq}, exp_gle);
      end
      step();
      n_cmp++;
      if ({Gnt, Done, Busy} !== 9'b0) begin
         n_err++;
         $display("FAIL %s_idle: got gnt=%b done=%b busy=%b required 0", name, Gnt, Done, Busy);
      end
      $display("%s: req%0d a=%h b=%h -> gt/lt/eq=%b", name, id, a, b, {Gt, Lt, Eq});
   endtask

   task automatic test_single();
      serve_one("single", 2, 32'd7, 32'd3, 3'b100);
   endtask

   task automatic test_operands();
      serve_one("op_eq", 1, 32'd5, 32'd5, 3'b001);
      serve_one("op_lt", 3, 32'h0, 32'hFFFF_FFFF, 3'b010);
      serve_one("op_gt", 0, 32'hFFFF_FFFF, 32'h0, 3'b100);
   endtask

   task automatic test_latch();
      A_in[0 +: W] = 32'd5;
      B_in[0 +: W] = 32'd9;
      Req = 4'b0001;
      step();
      Req = '0;
      A_in[0 +: W] = 32'd100;
      step();
      n_cmp++;
      if ({Done, Gt, Lt, Eq} !== {4'b0001, 3'b010}) begin
         n_err++;
         $display("FAIL latch: got done=%b gt/lt/eq=%b required 0001/010", Done, {Gt, Lt, Eq});
      end
      $display("latch: done=%b gt/lt/eq=%b", Done, {Gt, Lt, Eq});
      step();
   endtask

   task automatic test_reset_mid();
      A_in[1*W +: W] = 32'd1;
      B_in[1*W +: W] = 32'd2;
      Req = 4'b0010;
      step();
      n_cmp++;
      if (Gnt !== 4'b0010) begin
         n_err++;
         $display("FAIL rst_mid_gnt: got %b required 0010", Gnt);
      end
      Rst_n = 1'b0;
      step();
      n_cmp++;
      if ({Done, Gnt, Busy} !== 9'b0) begin
         n_err++;
         $display("FAIL rst_mid_abort: got done=%b gnt=%b busy=%b required 0", Done, Gnt, Busy);
      end
      Rst_n = 1'b1;
      step();
      n_cmp++;
      if ({Gnt, Done, Busy} !== {4'b0010, 4'b0000, 1'b1}) begin
         n_err++;
         $display("FAIL rst_mid_regrant: got gnt=%b done=%b busy=%b required 0010/0000/1",
                  Gnt, Done, Busy);
      end
      step();
      Req = '0;
      n_cmp++;
      if ({Done, Gt, Lt, Eq} !== {4'b0010, 3'b010}) begin
         n_err++;
         $display("FAIL rst_mid_done: got done=%b gt/lt/eq=%b required 0010/010", Done, {Gt, Lt, Eq});
      end
      $display("reset_mid: done=%b gt/lt/eq=%b after restart", Done, {Gt, Lt, Eq});
      step();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_operands();
      test_latch();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
